vme_slave_ctrl: RTL and testbench

// VME A16/D16 slave cycle controller; sits directly upstream of the register address decoder.

---
 rtl/vme_slave_ctrl.sv | 154 +++++++++++++++
 tb/tb_vme_slave_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vme_slave_ctrl.sv
// VME A16/D16 slave cycle controller.
// Synchronises the asynchronous bus strobes, qualifies AM code and board base,
// latches the cycle address for the register decoder, issues one-cycle
// read/write strobes and answers the master with DTACK* or BERR*.
module vme_slave_ctrl #(
  parameter logic [7:0] BASE_HI = 8'h7C,
  parameter logic [5:0] AM_SUP  = 6'h2D,
  parameter logic [5:0] AM_USR  = 6'h29,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] VME_A,
  input  logic [5:0]  VME_AM,
  input  logic        VME_AS_N,
  input  logic        VME_DS0_N,
  input  logic        VME_DS1_N,
  input  logic        VME_WRITE_N,
  output logic        VME_DTACK_N,
  output logic        VME_BERR_N,
  output logic [15:0] ADDR,
  input  logic        REG_HIT,
  output logic        RD_STB,
  output logic        WR_STB,
  input  logic        REG_ACK,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_IGNORE, S_DECODE, S_ACCESS, S_ACK, S_ERR, S_RELEASE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_sync_m;   // {AS, DS0, DS1, WRITE} first stage
  logic [3:0]  r_sync_s;   // second stage, safe to use
  logic [15:0] r_addr;
  logic        r_wr;
  logic        r_dtack_n;
  logic        r_berr_n;
  logic        r_rd_stb;
  logic        r_wr_stb;
  logic [7:0]  r_cnt;

  logic w_as_s;
  logic w_ds_act;
  logic w_write_s;
  logic w_match;
  logic w_tmo;
  logic w_unused;

  assign w_as_s    = r_sync_s[3];
  assign w_ds_act  = ~r_sync_s[2] | ~r_sync_s[1];
  assign w_write_s = r_sync_s[0];
  // Address/AM are stable while AS is low, so they are used unsynchronised.
  assign w_match   = ((VME_AM == AM_SUP) || (VME_AM == AM_USR)) &&
                     (VME_A[15:8] == BASE_HI);
  assign w_tmo     = (r_cnt == (TIMEOUT - 8'd1));
  assign w_unused  = VME_A[0];

  // Two-flop synchronisers for the asynchronous bus strobes (idle high).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync_m <= '1;
      r_sync_s <= '1;
    end else begin
      r_sync_m <= {VME_AS_N, VME_DS0_N, VME_DS1_N, VME_WRITE_N};
      r_sync_s <= r_sync_m;
    end
  end

  // Cycle FSM with registered bus responses and register-file strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_dtack_n <= 1'b1;
      r_berr_n  <= 1'b1;
      r_rd_stb  <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_rd_stb <= 1'b0;
      r_wr_stb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_as_s && w_ds_act) begin
            r_addr  <= {VME_A[15:1], 1'b0};
            r_wr    <= ~w_write_s;
            r_state <= w_match ? S_DECODE : S_IGNORE;
          end
        end
        S_IGNORE: begin
          if (w_as_s) r_state <= S_IDLE;
        end
        S_DECODE: begin
          r_cnt <= '0;
          if (w_as_s) begin
            r_state <= S_IDLE;
          end else if (REG_HIT) begin
            r_rd_stb <= ~r_wr;
            r_wr_stb <= r_wr;
            r_state  <= S_ACCESS;
          end else begin
            r_berr_n <= 1'b0;
            r_state  <= S_ERR;
          end
        end
        // The timeout compare looks one count ahead so BERR* lands exactly
        // TIMEOUT cycles after the strobe; REG_ACK is tested first so it wins.
        S_ACCESS: begin
          if (w_as_s) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (REG_ACK) begin
            r_cnt     <= '0;
            r_dtack_n <= 1'b0;
            r_state   <= S_ACK;
          end else if (w_tmo) begin
            r_cnt    <= '0;
            r_berr_n <= 1'b0;
            r_state  <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_ACK: begin
          if (!w_ds_act) begin
            r_dtack_n <= 1'b1;
            r_state   <= S_RELEASE;
          end
        end
        S_ERR: begin
          if (!w_ds_act) begin
            r_berr_n <= 1'b1;
            r_state  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (w_as_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign VME_DTACK_N = r_dtack_n;
  assign VME_BERR_N  = r_berr_n;
  assign ADDR        = r_addr;
  assign RD_STB      = r_rd_stb;
  assign WR_STB      = r_wr_stb;
  assign BUSY        = (r_state != S_IDLE);

endmodule

// File: tb/tb_vme_slave_ctrl.sv
// Self-checking bench for vme_slave_ctrl: directed and randomized VME cycles
// compared against a transaction-level outcome model.
module tb_vme_slave_ctrl;

  localparam int T = 255;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] VME_A;
  logic [5:0]  VME_AM;
  logic        VME_AS_N, VME_DS0_N, VME_DS1_N, VME_WRITE_N;
  logic        VME_DTACK_N, VME_BERR_N;
  logic [15:0] ADDR;
  logic        REG_HIT;
  logic        RD_STB, WR_STB;
  logic        REG_ACK;
  logic        BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  // Register decoder stand-in: registers live where address bit 4 is clear.
  assign REG_HIT = ~ADDR[4];

  vme_slave_ctrl #(
    .BASE_HI(8'h7C), .AM_SUP(6'h2D), .AM_USR(6'h29), .TIMEOUT(8'(T))
  ) dut (
    .CLK(CLK), .RST(RST), .VME_A(VME_A), .VME_AM(VME_AM),
    .VME_AS_N(VME_AS_N), .VME_DS0_N(VME_DS0_N), .VME_DS1_N(VME_DS1_N),
    .VME_WRITE_N(VME_WRITE_N), .VME_DTACK_N(VME_DTACK_N),
    .VME_BERR_N(VME_BERR_N), .ADDR(ADDR), .REG_HIT(REG_HIT),
    .RD_STB(RD_STB), .WR_STB(WR_STB), .REG_ACK(REG_ACK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: normal cycle, 1: master abort (AS high) during ACCESS,
  // 2: reset pulse while DTACK* is asserted.
  task automatic run_txn(input logic [15:0] a, input logic [5:0] am,
                         input bit wr, input int ackdly, input int mode);
    bit exp_match, exp_hit, exp_ack, exp_berr, got_dt;
    int strobe_at, resp_at, nrd, nwr, overlap, budget, rel_at, idle_at, r;
    exp_match = ((am == 6'h2D) || (am == 6'h29)) && (a[15:8] == 8'h7C);
    exp_hit   = exp_match && !a[4];
    exp_ack   = exp_hit && (ackdly <= T - 1) && (mode != 1);
    exp_berr  = exp_match && !exp_ack && (mode != 1);
    strobe_at = -1; resp_at = -1; nrd = 0; nwr = 0; overlap = 0; got_dt = 0;
    budget    = exp_match ? T + 20 : 12;

    VME_A = a; VME_AM = am; VME_WRITE_N = ~wr; VME_AS_N = 1'b0;
    r = $urandom_range(0, 2);
    VME_DS0_N = (r == 1); VME_DS1_N = (r == 2);

    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge CLK);
      if (RD_STB) begin nrd++; if (strobe_at < 0) strobe_at = cyc; end
      if (WR_STB) begin nwr++; if (strobe_at < 0) strobe_at = cyc; end
      if (RD_STB && WR_STB) overlap++;
      if (!VME_DTACK_N && !VME_BERR_N) overlap++;
      if (resp_at < 0 && (!VME_DTACK_N || !VME_BERR_N)) begin
        resp_at = cyc; got_dt = !VME_DTACK_N;
      end
      REG_ACK = (mode != 1) && (strobe_at >= 0) && (cyc == strobe_at + ackdly);
      if (mode == 1 && strobe_at >= 0 && cyc == strobe_at + 2) begin
        VME_AS_N = 1'b1; VME_DS0_N = 1'b1; VME_DS1_N = 1'b1;
        break;
      end
      if (resp_at >= 0) break;
    end
    REG_ACK = 1'b0;
    chk("overlap", overlap, 0);

    if (mode == 1) begin
      @(negedge CLK); @(negedge CLK);
      chk("abort_busy_sync", BUSY, 1);
      @(negedge CLK);
      chk("abort_busy", BUSY, 0);
      chk("abort_dtack", VME_DTACK_N, 1);
      chk("abort_berr", VME_BERR_N, 1);
      chk("abort_strobes", nrd + nwr, 1);
      @(negedge CLK);
      return;
    end

    chk("rd_cnt", nrd, exp_hit && !wr);
    chk("wr_cnt", nwr, exp_hit && wr);
    if (exp_hit) chk("strobe_lat", strobe_at, 4);
    chk("resp_dtack", (resp_at >= 0) && got_dt, exp_ack);
    chk("resp_berr", (resp_at >= 0) && !got_dt, exp_berr);
    if (exp_ack) chk("ack_lat", resp_at, strobe_at + ackdly + 1);
    if (exp_hit && exp_berr) chk("tmo_lat", resp_at - strobe_at, T);
    if (exp_match && !exp_hit) chk("err_lat", resp_at, 4);
    if (exp_match) chk("addr", ADDR, {a[15:1], 1'b0});
    if (!exp_match) chk("ign_busy", BUSY, 1);

    if (mode == 2) begin
      RST = 1'b1; VME_AS_N = 1'b1; VME_DS0_N = 1'b1; VME_DS1_N = 1'b1;
      @(negedge CLK);
      chk("rst_dtack", VME_DTACK_N, 1);
      chk("rst_busy", BUSY, 0);
      chk("rst_addr", ADDR, 0);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_quiet", BUSY, 0);
      return;
    end

    VME_DS0_N = 1'b1; VME_DS1_N = 1'b1;
    rel_at = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      if (VME_DTACK_N && VME_BERR_N) begin rel_at = i; break; end
    end
    if (exp_match) chk("ds_rel_lat", rel_at, 3);

    VME_AS_N = 1'b1;
    idle_at = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      if (!BUSY) begin idle_at = i; break; end
    end
    chk("as_rel_lat", idle_at, 3);
    @(negedge CLK);
  endtask

  initial begin
    logic [15:0] a;
    logic [5:0]  am;
    int          d, p;
    RST = 1'b1; VME_A = '0; VME_AM = '0; VME_AS_N = 1'b1; VME_DS0_N = 1'b1;
    VME_DS1_N = 1'b1; VME_WRITE_N = 1'b1; REG_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_dtack", VME_DTACK_N, 1);
    chk("rst_berr", VME_BERR_N, 1);
    chk("rst_rd", RD_STB, 0);
    chk("rst_wr", WR_STB, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_busy", BUSY, 0);
    RST = 1'b0;
    @(negedge CLK);

    run_txn(16'h7C84, 6'h2D, 1'b1, 2, 0);     // write, ack after 2
    run_txn(16'h7CA4, 6'h29, 1'b0, 0, 0);     // read, minimum latency
    run_txn(16'h7D80, 6'h2D, 1'b0, 0, 0);     // wrong base
    run_txn(16'h7C84, 6'h3D, 1'b1, 0, 0);     // wrong AM
    run_txn(16'h7C92, 6'h2D, 1'b0, 0, 0);     // no register hit
    run_txn(16'h7C85, 6'h2D, 1'b0, 1000, 0);  // never acked -> timeout
    run_txn(16'h7C44, 6'h29, 1'b1, T - 1, 0); // ack on timeout cycle
    run_txn(16'h7C20, 6'h2D, 1'b1, T, 0);     // ack one cycle late
    run_txn(16'h7C08, 6'h29, 1'b0, 1000, 1);  // master abort
    run_txn(16'h7C0C, 6'h2D, 1'b1, 1, 2);     // reset during ACK

    for (int k = 0; k < 40; k++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a[15:8] = 8'h7C;
      p = $urandom_range(0, 3);
      am = (p == 0) ? 6'h2D : (p == 1) ? 6'h29 : (p == 2) ? 6'h3D : 6'($urandom);
      d = ($urandom_range(0, 9) == 0) ? T - 1 + $urandom_range(0, 1) : $urandom_range(0, 4);
      run_txn(a, am, 1'($urandom), d, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
